clock_alarm_12h: RTL and testbench
==================================

Name: clock_alarm_12h

Overview:
- Alarm stage directly downstream of the 12-hour BCD clock counter.
- Consumes the live time (hh, mm, ss, pm) plus the same 1 Hz ena tick that advances the clock.
- Holds a programmable alarm time; raises ring when the live time reaches it.
- Times out the ring and supports stop and a bounded snooze.

Parameters:
- RING_SECS, 60: ena ticks the ring stays asserted before auto-stop (1..255).
- SNOOZE_MIN, 5: snooze length in minutes; converted to SNOOZE_MIN*60 ena ticks (1..30).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..7).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ena  in  1  1 Hz tick, one clk wide; same signal that advances the clock
- hh  in  8  live hours, BCD {tens,ones}, 01..12
- mm  in  8  live minutes, BCD 00..59
- ss  in  8  live seconds, BCD 00..59
- pm  in  1  live PM flag
- set_alarm  in  1  load strobe for set_hh/set_mm/set_pm
- set_hh  in  8  alarm hours, BCD
- set_mm  in  8  alarm minutes, BCD
- set_pm  in  1  alarm PM flag
- alarm_on  in  1  arm enable (level)
- stop  in  1  cancel ring/snooze (pulse)
- snooze  in  1  snooze request (pulse)
- al_hh  out  8  stored alarm hours
- al_mm  out  8  stored alarm minutes
- al_pm  out  1  stored alarm PM
- ring  out  1  alarm sounding
- snoozing  out  1  snooze countdown active
- set_err  out  1  one-cycle pulse: set_alarm rejected
- snooze_cnt  out  3  snoozes used in current event

Behaviour:
- Reset (async, reset_n=0):
  - al_hh=8'h12, al_mm=8'h00, al_pm=0 (12:00 AM).
  - ring=0, snoozing=0, set_err=0, snooze_cnt=0.
  - State IDLE; all counters 0; match_q=0.
- All outputs are registered.
- set_alarm:
  - Accepted only if set_hh is valid BCD in 01..12 and set_mm is valid BCD in 00..59.
  - Accepted: al_* update on the next edge. If the state is not IDLE, it also forces IDLE, clears the counters, and clears snooze_cnt.
  - Rejected: al_* unchanged; set_err=1 for one cycle.
- match = alarm_on & (hh==al_hh) & (mm==al_mm) & (ss==8'h00) & (pm==al_pm); registered as match_q.
- trigger = match & ~match_q. This fires once per event even though the time holds for many clk cycles.
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE -> RINGING on trigger. ring=1 from the next edge; ring counter cleared.
  - RINGING:
    - Ring counter increments on each ena.
    - When the counter reaches RING_SECS on an ena -> IDLE; ring=0 next edge; snooze_cnt cleared.
    - snooze with snooze_cnt < MAX_SNOOZE -> SNOOZE; snooze_cnt+1; snooze counter cleared.
    - snooze with snooze_cnt == MAX_SNOOZE is ignored.
  - SNOOZE: snoozing=1, ring=0. Snooze counter increments on ena. When it reaches SNOOZE_MIN*60 -> RINGING with the ring counter cleared.
- Priority in the same cycle: set_alarm (accepted) > stop > snooze > timeout/trigger.
- stop from any state -> IDLE; ring and snoozing drop next edge; snooze_cnt cleared.
- alarm_on deasserted:
  - Blocks new triggers only; it does not stop an active ring.
  - In SNOOZE, the expiry returns to IDLE instead of RINGING.
- Counter widths:
  - Ring counter: 8 bits.
  - Snooze counter: 11 bits (max 1800).
  - Both saturate-free; cleared on every state entry.
- The clock wrapping 11:59:59 -> 12:00:00 toggles pm. A match requires the pm equality, so 12:00 AM ≠ 12:00 PM.

Optional Feature:
- Macro: CLOCK_ALARM_SNOOZE_EN.
- Defined: SNOOZE state, snooze counter and snooze_cnt behave as above.
- Undefined:
  - snooze input is ignored.
  - SNOOZE state and snooze counter are not synthesised.
  - snoozing=0 and snooze_cnt=0 constantly.

Decomposition:
- Package clock_alarm_pkg holds:
  - alarm_state_e enum (IDLE, RINGING, SNOOZE).
  - BCD digit typedef.
  - ALARM_RST_HH/MM/PM constants.
  - function bcd_hh_valid / bcd_mm_valid.
- One sub-module, alarm_tick_counter: ena-gated counter with clear, terminal-count compare and parameterised width. Instantiated twice (ring and snooze).

Test Plan:
- Set 06:30 AM, alarm_on=1, drive time to 06:30:00 pm=0 held 5000 clk -> ring rises on the cycle after match and stays high; the trigger fires exactly once.
- RING_SECS=60, no stop: 60 ena pulses after ring rises -> ring=0, state IDLE, snooze_cnt=0.
- Snooze during ring, SNOOZE_MIN=5 -> snoozing=1, ring=0, snooze_cnt=1; after 300 ena pulses ring=1. The fourth snooze with MAX_SNOOZE=3 is ignored and ring stays 1.
- set_alarm with set_hh=8'h13 or set_mm=8'h5A -> set_err pulses once; al_hh/al_mm remain at their previous values.
- Alarm 12:00 PM, live time 12:00:00 with pm=0 -> no ring; with pm=1 -> ring=1.
- reset_n low mid-ring for 1 ns, asynchronous to clk -> ring=0 immediately; al_hh=8'h12, al_mm=8'h00, al_pm=0.

Source files
------------

// File: rtl/clock_alarm_pkg.sv
// Shared types, reset constants and BCD range checks for the 12-hour alarm stage.
package clock_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] ALARM_RST_HH = 8'h12;
  localparam logic [7:0] ALARM_RST_MM = 8'h00;
  localparam logic       ALARM_RST_PM = 1'b0;

  // Hours on a 12-hour face run 01..12; 00 is not a valid setting.
  function automatic logic bcd_hh_valid(input logic [7:0] v);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = v[7:4];
    ones = v[3:0];
    return ((tens == 4'd0) && (ones >= 4'd1) && (ones <= 4'd9)) ||
           ((tens == 4'd1) && (ones <= 4'd2));
  endfunction

  function automatic logic bcd_mm_valid(input logic [7:0] v);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = v[7:4];
    ones = v[3:0];
    return (tens <= 4'd5) && (ones <= 4'd9);
  endfunction

endpackage

// File: rtl/alarm_tick_counter.sv
// Ena-gated up-counter with synchronous clear; tc_hit flags the ena that completes TC ticks.
module alarm_tick_counter #(
  parameter int unsigned W  = 8,
  parameter int unsigned TC = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ena,
  output logic tc_hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ena) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Combinational so the owner can leave its state on the very tick that completes the count.
  assign tc_hit = ena && (cnt_q == W'(TC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_alarm_12h.sv
// Alarm stage for the 12-hour BCD clock: match/trigger, ring timeout, stop and snooze.
// Snooze support is built only when CLOCK_ALARM_SNOOZE_EN is defined.
module clock_alarm_12h
  import clock_alarm_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       set_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       alarm_on,
  input  logic       stop,
  input  logic       snooze,
  output logic [7:0] al_hh,
  output logic [7:0] al_mm,
  output logic       al_pm,
  output logic       ring,
  output logic       snoozing,
  output logic       set_err,
  output logic [2:0] snooze_cnt
);

  localparam int unsigned SNOOZE_TICKS = SNOOZE_MIN * 60;

  alarm_state_e state_q, state_d;
  logic [7:0]   al_hh_q, al_hh_d;
  logic [7:0]   al_mm_q, al_mm_d;
  logic         al_pm_q, al_pm_d;
  logic         ring_q, ring_d;
  logic         set_err_q, set_err_d;
  logic         match_q, match;
  logic         set_ok, set_acc, trigger;
  logic         ring_hit, snz_hit, snooze_go;
  logic         scnt_clr, scnt_inc;

  assign set_ok  = bcd_hh_valid(set_hh) && bcd_mm_valid(set_mm);
  assign set_acc = set_alarm && set_ok;
  assign match   = alarm_on && (hh == al_hh_q) && (mm == al_mm_q) &&
                   (ss == 8'h00) && (pm == al_pm_q);
  // The live time sits on the alarm second for many clk cycles; only the rising edge counts.
  assign trigger = match && !match_q;

  alarm_tick_counter #(.W(8), .TC(RING_SECS)) u_ring_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (state_q != RINGING),
    .ena    (ena && (state_q == RINGING)),
    .tc_hit (ring_hit)
  );

`ifdef CLOCK_ALARM_SNOOZE_EN
  logic [2:0] scnt_q, scnt_d;
  logic       snoozing_q, snoozing_d;

  alarm_tick_counter #(.W(11), .TC(SNOOZE_TICKS)) u_snooze_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (state_q != SNOOZE),
    .ena    (ena && (state_q == SNOOZE)),
    .tc_hit (snz_hit)
  );

  assign snooze_go = snooze && (scnt_q < 3'(MAX_SNOOZE));

  always_comb begin
    scnt_d = scnt_q;
    if (scnt_clr) begin
      scnt_d = 3'd0;
    end else if (scnt_inc) begin
      scnt_d = scnt_q + 3'd1;
    end
    snoozing_d = (state_d == SNOOZE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt_q     <= 3'd0;
      snoozing_q <= 1'b0;
    end else begin
      scnt_q     <= scnt_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign snoozing   = snoozing_q;
  assign snooze_cnt = scnt_q;
`else
  logic unused_snooze_cfg;

  assign snz_hit           = 1'b0;
  assign snooze_go         = 1'b0;
  assign unused_snooze_cfg = snooze ^ scnt_clr ^ scnt_inc ^
                             (SNOOZE_TICKS == 0) ^ (MAX_SNOOZE == 0);
  assign snoozing          = 1'b0;
  assign snooze_cnt        = 3'd0;
`endif

  // Priority: accepted set > stop > snooze > timeout/trigger.
  always_comb begin
    state_d   = state_q;
    al_hh_d   = al_hh_q;
    al_mm_d   = al_mm_q;
    al_pm_d   = al_pm_q;
    set_err_d = set_alarm && !set_ok;
    scnt_clr  = 1'b0;
    scnt_inc  = 1'b0;
    if (set_acc) begin
      al_hh_d  = set_hh;
      al_mm_d  = set_mm;
      al_pm_d  = set_pm;
      state_d  = IDLE;
      scnt_clr = 1'b1;
    end else if (stop) begin
      state_d  = IDLE;
      scnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) state_d = RINGING;
        end
        RINGING: begin
          if (snooze_go) begin
            state_d  = SNOOZE;
            scnt_inc = 1'b1;
          end else if (ring_hit) begin
            state_d  = IDLE;
            scnt_clr = 1'b1;
          end
        end
        SNOOZE: begin
          if (snz_hit) begin
            if (alarm_on) begin
              state_d = RINGING;
            end else begin
              state_d  = IDLE;
              scnt_clr = 1'b1;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          scnt_clr = 1'b1;
        end
      endcase
    end
    ring_d = (state_d == RINGING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      al_hh_q   <= ALARM_RST_HH;
      al_mm_q   <= ALARM_RST_MM;
      al_pm_q   <= ALARM_RST_PM;
      ring_q    <= 1'b0;
      set_err_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      al_hh_q   <= al_hh_d;
      al_mm_q   <= al_mm_d;
      al_pm_q   <= al_pm_d;
      ring_q    <= ring_d;
      set_err_q <= set_err_d;
      match_q   <= match;
    end
  end

  assign al_hh   = al_hh_q;
  assign al_mm   = al_mm_q;
  assign al_pm   = al_pm_q;
  assign ring    = ring_q;
  assign set_err = set_err_q;

endmodule

// File: tb/tb_clock_alarm_12h.sv
// Scoreboard bench for clock_alarm_12h; snooze scenarios follow CLOCK_ALARM_SNOOZE_EN.
module tb_clock_alarm_12h;

  localparam int S_RING = 0;
  localparam int S_SNZ  = 1;
  localparam int S_SCNT = 2;
  localparam int S_HH   = 3;
  localparam int S_MM   = 4;
  localparam int S_PM   = 5;
  localparam int S_ERR  = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena;
  logic [7:0] hh, mm, ss;
  logic       pm;
  logic       set_alarm;
  logic [7:0] set_hh, set_mm;
  logic       set_pm;
  logic       alarm_on, stop, snooze;
  logic [7:0] al_hh, al_mm;
  logic       al_pm, ring, snoozing, set_err;
  logic [2:0] snooze_cnt;

  always #5 clk = ~clk;

  clock_alarm_12h #(.RING_SECS(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .pm         (pm),
    .set_alarm  (set_alarm),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .set_pm     (set_pm),
    .alarm_on   (alarm_on),
    .stop       (stop),
    .snooze     (snooze),
    .al_hh      (al_hh),
    .al_mm      (al_mm),
    .al_pm      (al_pm),
    .ring       (ring),
    .snoozing   (snoozing),
    .set_err    (set_err),
    .snooze_cnt (snooze_cnt)
  );

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rises  = 0;
  logic ring_prev = 1'b0;

  always @(posedge clk) begin
    ring_prev <= ring;
    if (ring === 1'b1 && ring_prev === 1'b0) rises <= rises + 1;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_of(input int sel);
    case (sel)
      S_RING:  return {7'd0, ring};
      S_SNZ:   return {7'd0, snoozing};
      S_SCNT:  return {5'd0, snooze_cnt};
      S_HH:    return al_hh;
      S_MM:    return al_mm;
      S_PM:    return {7'd0, al_pm};
      default: return {7'd0, set_err};
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [7:0] val);
    sb_q.push_back('{tag, sel, val});
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ena = 1'b1;
    cyc();
    ena = 1'b0;
    cyc();
  endtask

  task automatic load_alarm(input logic [7:0] h, input logic [7:0] m, input logic p);
    set_hh    = h;
    set_mm    = m;
    set_pm    = p;
    set_alarm = 1'b1;
    cyc();
    set_alarm = 1'b0;
  endtask

  logic [7:0] bad_hh [4];
  logic [7:0] bad_mm [4];
  int         r0;

  initial begin
    bad_hh = '{8'h13, 8'h11, 8'h00, 8'h0A};
    bad_mm = '{8'h00, 8'h5A, 8'h15, 8'h00};
    reset_n = 1'b0; ena = 1'b0; set_alarm = 1'b0; alarm_on = 1'b0;
    stop = 1'b0; snooze = 1'b0; set_hh = 8'h00; set_mm = 8'h00; set_pm = 1'b0;
    hh = 8'h01; mm = 8'h00; ss = 8'h00; pm = 1'b0;
    repeat (3) cyc();
    sb_push("rst_ring", S_RING, 8'd0);
    sb_push("rst_snz",  S_SNZ,  8'd0);
    sb_push("rst_scnt", S_SCNT, 8'd0);
    sb_push("rst_hh",   S_HH,   8'h12);
    sb_push("rst_mm",   S_MM,   8'h00);
    sb_push("rst_pm",   S_PM,   8'd0);
    sb_push("rst_err",  S_ERR,  8'd0);
    drain();
    reset_n = 1'b1;
    cyc();

    load_alarm(8'h06, 8'h30, 1'b0);
    sb_push("set_hh", S_HH, 8'h06);
    sb_push("set_mm", S_MM, 8'h30);
    sb_push("set_pm", S_PM, 8'd0);
    sb_push("set_ok_err", S_ERR, 8'd0);
    drain();

    hh = 8'h06; mm = 8'h29; ss = 8'h59; pm = 1'b0; alarm_on = 1'b1;
    repeat (2) cyc();
    sb_push("pre_match", S_RING, 8'd0);
    drain();
    mm = 8'h30; ss = 8'h00;
    r0 = rises;
    cyc();
    sb_push("ring_rise", S_RING, 8'd1);
    drain();
    repeat (5000) cyc();
    sb_push("ring_hold", S_RING, 8'd1);
    drain();
    check_eq("trig_once", 8'(rises - r0), 8'd1);

    ss = 8'h01;
    repeat (59) tick();
    sb_push("ring_59", S_RING, 8'd1);
    drain();
    tick();
    sb_push("ring_timeout", S_RING, 8'd0);
    sb_push("timeout_scnt", S_SCNT, 8'd0);
    sb_push("timeout_snz", S_SNZ, 8'd0);
    drain();

    ss = 8'h00;
    cyc();
    sb_push("retrigger", S_RING, 8'd1);
    drain();
`ifdef CLOCK_ALARM_SNOOZE_EN
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      cyc();
      snooze = 1'b0;
      sb_push("snz_on", S_SNZ, 8'd1);
      sb_push("snz_ring", S_RING, 8'd0);
      sb_push("snz_cnt", S_SCNT, 8'(k));
      drain();
      repeat (299) tick();
      sb_push("snz_299", S_SNZ, 8'd1);
      sb_push("snz_299_ring", S_RING, 8'd0);
      drain();
      tick();
      sb_push("snz_expire_ring", S_RING, 8'd1);
      sb_push("snz_expire_snz", S_SNZ, 8'd0);
      sb_push("snz_expire_cnt", S_SCNT, 8'(k));
      drain();
    end
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    sb_push("snz_max_ring", S_RING, 8'd1);
    sb_push("snz_max_snz", S_SNZ, 8'd0);
    sb_push("snz_max_cnt", S_SCNT, 8'd3);
    drain();
`else
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    sb_push("snz_ign_ring", S_RING, 8'd1);
    sb_push("snz_ign_snz", S_SNZ, 8'd0);
    sb_push("snz_ign_cnt", S_SCNT, 8'd0);
    drain();
`endif
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    sb_push("stop_ring", S_RING, 8'd0);
    sb_push("stop_snz", S_SNZ, 8'd0);
    sb_push("stop_cnt", S_SCNT, 8'd0);
    drain();

    for (int i = 0; i < 4; i++) begin
      load_alarm(bad_hh[i], bad_mm[i], 1'b1);
      sb_push("bad_err", S_ERR, 8'd1);
      sb_push("bad_hh", S_HH, 8'h06);
      sb_push("bad_mm", S_MM, 8'h30);
      sb_push("bad_pm", S_PM, 8'd0);
      drain();
      cyc();
      sb_push("bad_err_clr", S_ERR, 8'd0);
      drain();
    end

    load_alarm(8'h12, 8'h00, 1'b1);
    sb_push("pm_set_hh", S_HH, 8'h12);
    sb_push("pm_set_mm", S_MM, 8'h00);
    sb_push("pm_set_pm", S_PM, 8'd1);
    drain();
    hh = 8'h12; mm = 8'h00; ss = 8'h00; pm = 1'b0;
    repeat (3) cyc();
    sb_push("am_no_ring", S_RING, 8'd0);
    drain();
    pm = 1'b1;
    cyc();
    sb_push("pm_ring", S_RING, 8'd1);
    drain();

    #3 reset_n = 1'b0;
    #1;
    sb_push("async_ring", S_RING, 8'd0);
    sb_push("async_hh", S_HH, 8'h12);
    sb_push("async_mm", S_MM, 8'h00);
    sb_push("async_pm", S_PM, 8'd0);
    drain();
    reset_n = 1'b1;
    repeat (3) cyc();
    sb_push("post_rst_ring", S_RING, 8'd0);
    drain();

    alarm_on = 1'b0; pm = 1'b0;
    repeat (3) cyc();
    sb_push("gated", S_RING, 8'd0);
    drain();
    alarm_on = 1'b1;
    cyc();
    sb_push("armed", S_RING, 8'd1);
    drain();
    alarm_on = 1'b0;
    repeat (3) cyc();
    sb_push("ring_persists", S_RING, 8'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
